// File: rtl/victim_write_buffer_pkg.sv
// Shared types for the victim write buffer: drain FSM state encoding.
package victim_write_buffer_pkg;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_DRAIN = 1'b1
    } lc3b_wb_state;

endpackage

// File: rtl/victim_write_buffer_wb_tag_match.sv
// Fully-associative tag/valid compare across all slots; emits one-hot match and its encoded index.
module wb_tag_match
    import victim_write_buffer_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 12
) (
    input  logic [ENTRIES-1:0]            valid,
    input  logic [ENTRIES-1:0][TAG_W-1:0] tags,
    input  logic [TAG_W-1:0]              probe,
    output logic                          hit,
    output logic [ENTRIES-1:0]            onehot,
    output logic [$clog2(ENTRIES)-1:0]    idx
);

    localparam int IDX_W = $clog2(ENTRIES);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            onehot[i] = valid[i] && (tags[i] == probe);
        end
    end

    // Valid tags are unique, so OR-encoding the one-hot vector yields the index.
    always_comb begin
        idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

    assign hit = |onehot;

endmodule

// File: rtl/victim_write_buffer.sv
// Circular victim-line write buffer with merge-on-evict, associative lookup and a
// threshold/flush-driven drain FSM toward physical memory.
module victim_write_buffer
    import victim_write_buffer_pkg::*;
#(
    parameter int ENTRIES      = 4,
    parameter int LINE_W       = 128,
    parameter int ADDR_W       = 16,
    parameter int OFFSET_W     = 4,
    parameter int DRAIN_THRESH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     evict_write,
    input  logic [ADDR_W-1:0]        evict_address,
    input  logic [LINE_W-1:0]        evict_data,
    output logic                     evict_ready,
    input  logic [ADDR_W-1:0]        lookup_address,
    output logic                     lookup_hit,
    output logic [LINE_W-1:0]        lookup_data,
    output logic                     pmem_write,
    output logic [ADDR_W-1:0]        pmem_address,
    output logic [LINE_W-1:0]        pmem_wdata,
    input  logic                     pmem_resp,
    input  logic                     flush,
    output logic                     flush_done,
    output logic [$clog2(ENTRIES):0] count
);

    localparam int TAG_W = ADDR_W - OFFSET_W;
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    logic [ENTRIES-1:0]            valid_q;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
    logic [LINE_W-1:0]             data_q [ENTRIES];
    logic [IDX_W-1:0]              head_q;
    logic [IDX_W-1:0]              tail_q;
    logic [CNT_W-1:0]              count_q;
    logic [CNT_W-1:0]              count_nxt;
    lc3b_wb_state                  state_q;
    logic                          flush_pending_q;
    logic                          flush_done_q;

    logic [TAG_W-1:0]   ev_tag;
    logic [TAG_W-1:0]   lk_tag;
    logic               ev_hit;
    logic               lk_hit;
    logic [ENTRIES-1:0] ev_onehot;
    logic [ENTRIES-1:0] lk_onehot;
    logic [IDX_W-1:0]   ev_idx;
    logic [IDX_W-1:0]   lk_idx;

    logic head_busy;
    logic merge_ok;
    logic alloc_ok;
    logic do_merge;
    logic do_alloc;
    logic do_pop;
    logic start_drain;
    logic flush_req;
    logic flush_fin;
    logic unused_bits;

    assign ev_tag = evict_address[ADDR_W-1:OFFSET_W];
    assign lk_tag = lookup_address[ADDR_W-1:OFFSET_W];
    assign unused_bits = ^{evict_address[OFFSET_W-1:0], lookup_address[OFFSET_W-1:0],
                           ev_onehot, lk_onehot};

    wb_tag_match #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) u_evict_match (
        .valid  (valid_q),
        .tags   (tag_q),
        .probe  (ev_tag),
        .hit    (ev_hit),
        .onehot (ev_onehot),
        .idx    (ev_idx)
    );

    wb_tag_match #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) u_lookup_match (
        .valid  (valid_q),
        .tags   (tag_q),
        .probe  (lk_tag),
        .hit    (lk_hit),
        .onehot (lk_onehot),
        .idx    (lk_idx)
    );

    // The head line is in flight while draining, so it may be neither merged nor duplicated.
    assign head_busy   = (state_q == WB_DRAIN) && (ev_idx == head_q);
    assign merge_ok    = ev_hit && !head_busy;
    assign alloc_ok    = !ev_hit && (count_q < CNT_W'(ENTRIES));
    assign evict_ready = merge_ok || alloc_ok;
    assign do_merge    = evict_write && merge_ok;
    assign do_alloc    = evict_write && alloc_ok;
    assign do_pop      = (state_q == WB_DRAIN) && pmem_resp;
    assign start_drain = (count_q >= CNT_W'(DRAIN_THRESH)) ||
                         (flush_pending_q && (count_q != '0));

    always_comb begin
        count_nxt = count_q;
        if (do_alloc && !do_pop) begin
            count_nxt = count_q + CNT_W'(1);
        end else if (!do_alloc && do_pop) begin
            count_nxt = count_q - CNT_W'(1);
        end
    end

    // A flush completes in the cycle the buffer becomes (or already is) empty.
    assign flush_req = flush_pending_q || flush;
    assign flush_fin = flush_req && (count_nxt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q         <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            state_q         <= WB_IDLE;
            flush_pending_q <= 1'b0;
            flush_done_q    <= 1'b0;
        end else begin
            if (do_pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (do_alloc) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            count_q         <= count_nxt;
            flush_pending_q <= flush_req && !flush_fin;
            flush_done_q    <= flush_fin;
            case (state_q)
                WB_IDLE:  if (start_drain) state_q <= WB_DRAIN;
                WB_DRAIN: if (pmem_resp)   state_q <= WB_IDLE;
                default:                   state_q <= WB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_alloc) begin
            tag_q[tail_q]  <= ev_tag;
            data_q[tail_q] <= evict_data;
        end else if (do_merge) begin
            data_q[ev_idx] <= evict_data;
        end
    end

    assign lookup_hit   = lk_hit;
    assign lookup_data  = lk_hit ? data_q[lk_idx] : '0;
    assign pmem_write   = (state_q == WB_DRAIN);
    assign pmem_address = {tag_q[head_q], {OFFSET_W{1'b0}}};
    assign pmem_wdata   = data_q[head_q];
    assign flush_done   = flush_done_q;
    assign count        = count_q;

endmodule

// File: tb/tb_victim_write_buffer.sv
// Directed plus randomized bench for victim_write_buffer against a FIFO-of-lines reference model.
module tb_victim_write_buffer;

    localparam int ENTRIES  = 4;
    localparam int LINE_W   = 128;
    localparam int ADDR_W   = 16;
    localparam int OFFSET_W = 4;
    localparam int THRESH   = 4;
    localparam int TAG_W    = ADDR_W - OFFSET_W;
    localparam int CNT_W    = $clog2(ENTRIES) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              evict_write = 1'b0;
    logic [ADDR_W-1:0] evict_address = '0;
    logic [LINE_W-1:0] evict_data = '0;
    logic              evict_ready;
    logic [ADDR_W-1:0] lookup_address = '0;
    logic              lookup_hit;
    logic [LINE_W-1:0] lookup_data;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_resp = 1'b0;
    logic              flush = 1'b0;
    logic              flush_done;
    logic [CNT_W-1:0]  count;

    always #5 clk = ~clk;

    victim_write_buffer #(
        .ENTRIES(ENTRIES), .LINE_W(LINE_W), .ADDR_W(ADDR_W),
        .OFFSET_W(OFFSET_W), .DRAIN_THRESH(THRESH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .evict_write(evict_write), .evict_address(evict_address),
        .evict_data(evict_data), .evict_ready(evict_ready),
        .lookup_address(lookup_address), .lookup_hit(lookup_hit),
        .lookup_data(lookup_data),
        .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp),
        .flush(flush), .flush_done(flush_done), .count(count)
    );

    // Reference model: lines in FIFO order (index 0 is oldest), plus drain/flush flags.
    logic [TAG_W-1:0]  qt[$];
    logic [LINE_W-1:0] qd[$];
    bit m_drain, m_fp, m_done;

    int checks = 0;
    int failures = 0;

    localparam logic [LINE_W-1:0] D1 = {4{32'hD1D1_0001}};
    localparam logic [LINE_W-1:0] D2 = {4{32'hD2D2_0002}};
    localparam logic [LINE_W-1:0] D3 = {4{32'hD3D3_0003}};

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:OFFSET_W];
    endfunction

    function automatic int find(input logic [TAG_W-1:0] t);
        for (int i = 0; i < qt.size(); i++) begin
            if (qt[i] == t) return i;
        end
        return -1;
    endfunction

    function automatic logic [LINE_W-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qt.delete();
        qd.delete();
        m_drain = 0;
        m_fp    = 0;
        m_done  = 0;
    endtask

    // One clock: check outputs mid-cycle against the model, advance the model, end at posedge+1.
    task automatic step();
        int k, lk, sz0;
        bit rdy, pend;
        @(negedge clk);
        k   = find(tag_of(evict_address));
        rdy = (k >= 0) ? !(m_drain && k == 0) : (qt.size() < ENTRIES);
        lk  = find(tag_of(lookup_address));
        chk("evict_ready", evict_ready, rdy);
        chk("lookup_hit", lookup_hit, lk >= 0);
        chk("lookup_data", lookup_data, (lk >= 0) ? qd[lk] : '0);
        chk("pmem_write", pmem_write, m_drain);
        chk("count", count, qt.size());
        chk("flush_done", flush_done, m_done);
        if (m_drain) begin
            chk("pmem_address", pmem_address, {qt[0], {OFFSET_W{1'b0}}});
            chk("pmem_wdata", pmem_wdata, qd[0]);
        end
        sz0 = qt.size();
        if (evict_write && rdy) begin
            if (k >= 0) begin
                qd[k] = evict_data;
            end else begin
                qt.push_back(tag_of(evict_address));
                qd.push_back(evict_data);
            end
        end
        if (m_drain && pmem_resp) begin
            void'(qt.pop_front());
            void'(qd.pop_front());
        end
        pend    = m_fp || flush;
        m_done  = pend && (qt.size() == 0);
        m_fp    = pend && !m_done;
        m_drain = m_drain ? !pmem_resp : ((sz0 >= THRESH) || (m_fp_prev(pend, flush) && sz0 != 0));
        @(posedge clk);
        #1;
    endtask

    // Drain start looks at the flush_pending flag as it stood before this edge.
    bit fp_before;
    function automatic bit m_fp_prev(input bit pend, input logic fl);
        return pend && !(fl && !fp_before);
    endfunction

    task automatic do_step();
        fp_before = m_fp;
        step();
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
        evict_write   = 1'b1;
        evict_address = a;
        evict_data    = d;
        do_step();
        evict_write   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int wr_n, done_n;
    logic [ADDR_W-1:0] wr_addr[$];

    initial begin
        // Reset values
        rst_n = 1'b0;
        model_reset();
        #12;
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_lookup_hit", lookup_hit, 1'b0);
        chk("rst_evict_ready", evict_ready, 1'b1);
        chk("rst_count", count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First push and lookup
        lookup_address = 16'h1238;
        push(16'h1230, D1);
        #1;
        chk("push1_count", count, 1);
        chk("push1_no_pmem", pmem_write, 1'b0);
        chk("push1_hit", lookup_hit, 1'b1);
        chk("push1_data", lookup_data, D1);

        // Same-line merge
        push(16'h1230, D2);
        #1;
        chk("merge_count", count, 1);
        chk("merge_data", lookup_data, D2);

        // Fill, then observe full/ready behaviour and drain start
        push(16'h2000, rnd_line());
        push(16'h3000, rnd_line());
        push(16'h4000, rnd_line());
        evict_address = 16'h5000;
        #1;
        chk("full_new_tag_ready", evict_ready, 1'b0);
        chk("full_idle_pmem", pmem_write, 1'b0);
        evict_address = 16'h3008;
        #1;
        chk("full_resident_ready", evict_ready, 1'b1);
        do_step();
        chk("drain_pmem_write", pmem_write, 1'b1);
        chk("drain_addr", pmem_address, 16'h1230);
        chk("drain_data", pmem_wdata, D2);

        // Head line in flight: same-tag push held off until after resp
        evict_write   = 1'b1;
        evict_address = 16'h1230;
        evict_data    = D3;
        #1;
        chk("head_busy_ready", evict_ready, 1'b0);
        for (int i = 0; i < 5; i++) do_step();
        chk("hold_addr", pmem_address, 16'h1230);
        chk("hold_data", pmem_wdata, D2);
        pmem_resp = 1'b1;
        do_step();
        pmem_resp = 1'b0;
        chk("pop_count", count, 3);
        chk("pop_idle", pmem_write, 1'b0);
        chk("after_pop_ready", evict_ready, 1'b1);
        lookup_address = 16'h1230;
        do_step();
        evict_write = 1'b0;
        chk("realloc_count", count, 4);
        chk("realloc_data", lookup_data, D3);
        do_step();

        // Flush with two entries below threshold
        do_reset();
        push(16'h7770, rnd_line());
        push(16'h8880, rnd_line());
        flush = 1'b1;
        do_step();
        flush  = 1'b0;
        wr_n   = 0;
        done_n = 0;
        wr_addr.delete();
        for (int i = 0; i < 40 && done_n == 0; i++) begin
            pmem_resp = pmem_write;
            if (pmem_write) wr_addr.push_back(pmem_address);
            do_step();
            if (flush_done) done_n++;
        end
        pmem_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_step();
            if (flush_done) done_n++;
        end
        wr_n = wr_addr.size();
        chk("flush_writes", wr_n, 2);
        chk("flush_first", (wr_n > 0) ? wr_addr[0] : 16'hFFFF, 16'h7770);
        chk("flush_second", (wr_n > 1) ? wr_addr[1] : 16'hFFFF, 16'h8880);
        chk("flush_done_once", done_n, 1);
        chk("flush_count", count, 0);

        // Flush while empty
        flush = 1'b1;
        do_step();
        flush = 1'b0;
        chk("flush_empty_done", flush_done, 1'b1);
        do_step();
        chk("flush_empty_pulse", flush_done, 1'b0);

        // Asynchronous reset mid-drain
        push(16'h1000, rnd_line());
        push(16'h2000, rnd_line());
        push(16'h3000, rnd_line());
        push(16'h4000, rnd_line());
        do_step();
        chk("pre_rst_drain", pmem_write, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("async_rst_pmem", pmem_write, 1'b0);
        chk("async_rst_count", count, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lookup_address = 16'h1000;
        #1;
        chk("post_rst_miss", lookup_hit, 1'b0);

        // Randomized traffic with merges, drains, flushes and pointer wrap
        for (int i = 0; i < 600; i++) begin
            evict_write    = ($urandom_range(0, 2) != 0);
            evict_address  = ADDR_W'(($urandom_range(1, 6) << 8) | $urandom_range(0, 15));
            evict_data     = rnd_line();
            lookup_address = ADDR_W'(($urandom_range(1, 7) << 8) | $urandom_range(0, 15));
            pmem_resp      = $urandom_range(0, 1);
            flush          = ($urandom_range(0, 19) == 0);
            do_step();
        end

        // Final flush to empty
        evict_write = 1'b0;
        flush       = 1'b1;
        do_step();
        flush = 1'b0;
        for (int i = 0; i < 60 && !(qt.size() == 0 && !m_fp && !m_drain); i++) begin
            pmem_resp = 1'b1;
            do_step();
        end
        pmem_resp = 1'b0;
        do_step();
        chk("final_count", count, 0);
        chk("final_idle", pmem_write, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
